// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: per-state ALU/mux/enable decode, mem_ready handshake, optional memory timeout.
// Optional unconditional branch B (JUMP state) is compiled in when MULTICYCLE_CTRL_B_EN is defined.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        memtoReg,
  output logic        instr_done,
  output logic        fault
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_R_WB     = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_LD_WB    = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_HALT     = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [3:0]    state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          fault_q;
  logic          mem_wait;
  logic          timeout_hit;

  assign mem_wait    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // mem_ready in the final allowed cycle still completes the access
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_wait && !mem_ready &&
                       ((int'(wait_cnt) + 1) >= MEM_TIMEOUT);

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
                  else if (timeout_hit) state_next = S_HALT;
      S_DECODE: begin
        casez (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: state_next = S_EXEC_R;
          OP_LDUR, OP_STUR:               state_next = S_MEM_ADDR;
          11'b10110100???:                state_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_B_EN
          11'b000101?????:                state_next = S_JUMP;
`endif
          default:                        state_next = S_HALT;
        endcase
      end
      S_EXEC_R:   state_next = S_R_WB;
      S_R_WB:     state_next = S_FETCH;
      S_MEM_ADDR: state_next = (op == OP_LDUR) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_next = S_LD_WB;
                  else if (timeout_hit) state_next = S_HALT;
      S_LD_WB:    state_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
                  else if (timeout_hit) state_next = S_HALT;
      S_BRANCH:   state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
`ifdef MULTICYCLE_CTRL_B_EN
      S_JUMP:     state_next = S_FETCH;
`endif
      default:    state_next = S_HALT;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt;
    if (state_next != state) wait_cnt_next = '0;
    else if (mem_wait && !mem_ready) wait_cnt_next = wait_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state_next == S_HALT) fault_q <= 1'b1;
    end
  end

  always_comb begin
    ALUControl = 4'b0010;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    memtoReg   = 1'b0;
    instr_done = 1'b0;
    fault      = fault_q & ~reset;
    if (reset) begin
      ALUControl = 4'b0000;
    end else begin
      case (state)
        S_FETCH: begin
          memRead = 1'b1;
          ALUSrcB = 2'b01;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        // PC-relative branch target is computed here and parked in ALUOut
        S_DECODE: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b11;
        end
        S_EXEC_R: begin
          ALUSrcA = 2'b01;
          case (op)
            OP_SUB:  ALUControl = 4'b0110;
            OP_AND:  ALUControl = 4'b0000;
            OP_ORR:  ALUControl = 4'b0001;
            default: ALUControl = 4'b0010;
          endcase
        end
        S_R_WB: begin
          regWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_MEM_RD: memRead = 1'b1;
        S_LD_WB: begin
          regWrite   = 1'b1;
          memtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          memWrite   = 1'b1;
          instr_done = mem_ready;
        end
        S_BRANCH: begin
          ALUControl = 4'b0111;
          PCSrc      = 1'b1;
          PCWrite    = zero;
          instr_done = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_B_EN
        S_JUMP: begin
          PCSrc      = 1'b1;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle LEGv8 datapath; the issuing side of the ALU interface.
- Decodes the latched 11-bit opcode and, each state, drives ALUControl, ALU operand selects, register-file/memory/PC enables.
- Consumes the ALU zero flag for CBZ.
- Handshakes with instruction/data memory through mem_ready.

Parameters:
- MEM_TIMEOUT, 0, max cycles waiting on mem_ready in a memory state before raising fault; 0 = no timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- op  input  11  instruction[31:21] from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes access this cycle
- ALUControl  output  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass b
- ALUSrcA  output  2  00 PC, 01 regA, 10 oldPC
- ALUSrcB  output  2  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
- IRWrite  output  1  latch instruction and oldPC
- PCWrite  output  1  PC load enable
- PCSrc  output  1  0 ALU result, 1 ALUOut register
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- regWrite  output  1  register-file write
- memtoReg  output  1  writeback source: 0 ALUOut, 1 memory data
- instr_done  output  1  one-cycle pulse when an instruction retires
- fault  output  1  sticky illegal-opcode / timeout flag

Behaviour:
- Reset (synchronous, active-high): next state FETCH, wait counter 0, fault 0. While reset is high, all outputs 0; ALUControl = 0000.
- Outputs are combinational from state, op, zero and mem_ready. Unlisted outputs are 0; ALUControl defaults to 0010.
- FETCH: memRead=1, ALUSrcA=00, ALUSrcB=01, ALUControl=0010.
  - On mem_ready: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE. Otherwise stay.
- DECODE: ALUSrcA=10, ALUSrcB=11, ALUControl=0010 (branch target into ALUOut). Dispatch on op:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R
  - LDUR 11111000010, STUR 11111000000 -> MEM_ADDR
  - CBZ 10110100xxx -> BRANCH
  - other -> HALT
- EXEC_R: ALUSrcA=01, ALUSrcB=00; ALUControl ADD 0010, SUB 0110, AND 0000, ORR 0001. Next R_WB.
- R_WB: regWrite=1, memtoReg=0, instr_done=1. Next FETCH.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUControl=0010. Next MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: memRead=1, held until mem_ready, then LD_WB.
- LD_WB: regWrite=1, memtoReg=1, instr_done=1. Next FETCH.
- MEM_WR: memWrite=1, held until mem_ready; that cycle instr_done=1. Next FETCH.
- BRANCH: ALUSrcB=00, ALUControl=0111 (test Rt). PCSrc=1, PCWrite=zero, instr_done=1. Next FETCH.
- HALT: fault=1; all enables 0; stays until reset.
- op is sampled only in DECODE and later states, never in FETCH. The IR is stable after IRWrite.
- Timeout (MEM_TIMEOUT>0):
  - Counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0 there.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, go to HALT with fault=1.
  - mem_ready=1 in that same cycle wins: no fault.
- Reset mid-access (any state) aborts the access; the next cycle is FETCH with memRead=1.
- Latency with mem_ready always 1: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_B_EN.
- When defined: DECODE additionally recognises B (op[10:5]=000101) and goes to JUMP. JUMP sets PCSrc=1, PCWrite=1, instr_done=1, then goes to FETCH (3 cycles total).
- When undefined: B opcode goes to HALT with fault=1.

Test Plan:
- Reset 2 cycles, mem_ready=1, op=ADD -> states FETCH,DECODE,EXEC_R,R_WB. ALUControl 0010 in EXEC_R; regWrite=1 and instr_done=1 only in cycle 4.
- op=SUB, AND, ORR in turn -> ALUControl 0110, 0000, 0001 in EXEC_R; ALUSrcA=01, ALUSrcB=00.
- op=LDUR, mem_ready low 3 cycles in MEM_RD -> memRead held 4 cycles; then LD_WB with memtoReg=1, regWrite=1; total 8 cycles.
- op=10110100101 (CBZ): zero=1 -> PCWrite=1, PCSrc=1. With zero=0 -> PCWrite=0. instr_done=1 in both cases.
- op=11111111111 -> HALT: fault=1 and stays 1 with all enables 0 for 10 cycles. Reset clears fault; next state FETCH.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> fault=1 after the 4th waiting cycle. Repeat with mem_ready=1 on cycle 4 -> no fault, DECODE next.
